// File: rtl/reg_bank_rw.sv
// 32 x DATA_W register file with two bypassed combinational read ports
// and the A/B operand latches of the multicycle datapath.
module reg_bank_rw #(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic              load_a,
  input  logic              load_b,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out
);

  localparam logic [4:0] SP_IDX = 5'd29;

  logic [DATA_W-1:0] regs [32];
  logic              wr_en;

  // r0 is hardwired: writes to it never land and it never bypasses.
  assign wr_en = reg_write && (write_reg != 5'd0);

  function automatic logic [DATA_W-1:0] read_port(
    input logic [4:0]        idx,
    input logic              we,
    input logic [4:0]        widx,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (idx == 5'd0)
      return '0;
    else if (we && (widx == idx))
      return wdata;
    else
      return stored;
  endfunction

  always_comb begin
    read_data1 = read_port(read_reg1, reg_write, write_reg, write_data, regs[read_reg1]);
    read_data2 = read_port(read_reg2, reg_write, write_reg, write_data, regs[read_reg2]);
  end

  // Array write and operand capture; reset overrides any write or load on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= (5'(i) == SP_IDX) ? DATA_W'(SP_INIT) : '0;
      a_out <= '0;
      b_out <= '0;
    end else begin
      if (wr_en)
        regs[write_reg] <= write_data;
      if (load_a)
        a_out <= read_data1;
      if (load_b)
        b_out <= read_data2;
    end
  end

endmodule

// File: tb/tb_reg_bank_rw.sv
// Self-checking bench for reg_bank_rw: directed scenarios plus randomized
// traffic compared against an array-based reference model.
module tb_reg_bank_rw;

  localparam int DATA_W  = 32;
  localparam int SP_INIT = 227;

  logic              clk = 1'b0;
  logic              reset;
  logic              reg_write;
  logic [4:0]        write_reg;
  logic [DATA_W-1:0] write_data;
  logic [4:0]        read_reg1;
  logic [4:0]        read_reg2;
  logic              load_a;
  logic              load_b;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] model [32];
  logic [DATA_W-1:0] model_a;
  logic [DATA_W-1:0] model_b;

  reg_bank_rw #(.DATA_W(DATA_W), .SP_INIT(SP_INIT)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .load_a(load_a), .load_b(load_b), .read_data1(read_data1),
    .read_data2(read_data2), .a_out(a_out), .b_out(b_out)
  );

  always #5 clk = ~clk;

  // Expected value of a read port given the current inputs and stored model.
  function automatic logic [DATA_W-1:0] exp_read(input logic [4:0] idx);
    if (idx == 0) return '0;
    if (reg_write && write_reg == idx) return write_data;
    return model[idx];
  endfunction

  // Advance one rising edge and update the reference model from the inputs seen there.
  task automatic tick();
    logic [DATA_W-1:0] r1, r2;
    @(posedge clk);
    r1 = exp_read(read_reg1);
    r2 = exp_read(read_reg2);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = (i == 29) ? DATA_W'(SP_INIT) : '0;
      model_a = '0;
      model_b = '0;
    end else begin
      if (reg_write && write_reg != 0) model[write_reg] = write_data;
      if (load_a) model_a = r1;
      if (load_b) model_b = r2;
    end
    #1;
  endtask

  task automatic idle();
    reset = 0; reg_write = 0; write_reg = 0; write_data = 0;
    read_reg1 = 0; read_reg2 = 0; load_a = 0; load_b = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    tick();
    reset = 0; read_reg1 = 29; read_reg2 = 5;
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'd227) begin n_fail++; $display("FAIL reset_sp got %h want %h", read_data1, 32'd227); end
    n_tests++;
    if (read_data2 !== 32'd0) begin n_fail++; $display("FAIL reset_r5 got %h want 0", read_data2); end
    n_tests++;
    if (a_out !== 32'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", a_out); end
    n_tests++;
    if (b_out !== 32'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", b_out); end
    tick();
  endtask

  task automatic test_write_read();
    idle();
    reg_write = 1; write_reg = 8; write_data = 32'hDEADBEEF;
    tick();
    idle(); read_reg1 = 8;
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_read got %h want deadbeef", read_data1); end
    tick();
  endtask

  task automatic test_zero_reg();
    idle();
    reg_write = 1; write_reg = 0; write_data = 32'h12345678;
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      n_fail++; $display("FAIL zero_bypass got %h/%h want 0/0", read_data1, read_data2);
    end
    tick();
    idle();
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'd0 || read_data2 !== 32'd0) begin
      n_fail++; $display("FAIL zero_after got %h/%h want 0/0", read_data1, read_data2);
    end
    tick();
  endtask

  task automatic test_bypass_latch();
    idle();
    reg_write = 1; write_reg = 31; write_data = 32'h00400008; read_reg2 = 31; load_b = 1;
    @(negedge clk);
    n_tests++;
    if (read_data2 !== 32'h00400008) begin n_fail++; $display("FAIL bypass_rd2 got %h want 00400008", read_data2); end
    tick();
    idle(); read_reg1 = 31;
    n_tests++;
    if (b_out !== 32'h00400008) begin n_fail++; $display("FAIL bypass_b got %h want 00400008", b_out); end
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'h00400008) begin n_fail++; $display("FAIL ra_hold got %h want 00400008", read_data1); end
    tick();
  endtask

  task automatic test_reset_priority();
    idle();
    read_reg1 = 5; load_a = 1;
    reg_write = 1; write_reg = 5; write_data = 32'h55;
    tick();
    idle();
    reset = 1; reg_write = 1; write_reg = 29; write_data = 5; load_a = 1; load_b = 1;
    read_reg1 = 29;
    tick();
    idle(); read_reg1 = 29; read_reg2 = 5;
    @(negedge clk);
    n_tests++;
    if (read_data1 !== 32'd227) begin n_fail++; $display("FAIL rstpri_sp got %h want %h", read_data1, 32'd227); end
    n_tests++;
    if (read_data2 !== 32'd0) begin n_fail++; $display("FAIL rstpri_r5 got %h want 0", read_data2); end
    n_tests++;
    if (a_out !== 32'd0) begin n_fail++; $display("FAIL rstpri_a got %h want 0", a_out); end
    tick();
  endtask

  task automatic test_hold();
    idle();
    reg_write = 1; write_reg = 8; write_data = 32'hDEADBEEF;
    tick();
    idle(); read_reg1 = 8; load_a = 1;
    tick();
    idle(); read_reg1 = 8; reg_write = 1; write_reg = 8; write_data = 32'd1;
    tick();
    idle(); read_reg1 = 8;
    @(negedge clk);
    n_tests++;
    if (a_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_a got %h want deadbeef", a_out); end
    n_tests++;
    if (read_data1 !== 32'd1) begin n_fail++; $display("FAIL hold_rd1 got %h want 1", read_data1); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 49) == 0);
      reg_write  = $urandom_range(0, 1);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 3) == 0) ? write_reg : 5'($urandom_range(0, 31));
      load_a     = $urandom_range(0, 1);
      load_b     = $urandom_range(0, 1);
      @(negedge clk);
      n_tests++;
      if (read_data1 !== exp_read(read_reg1)) begin
        n_fail++; $display("FAIL rand_rd1 cyc %0d idx %0d got %h want %h", c, read_reg1, read_data1, exp_read(read_reg1));
      end
      n_tests++;
      if (read_data2 !== exp_read(read_reg2)) begin
        n_fail++; $display("FAIL rand_rd2 cyc %0d idx %0d got %h want %h", c, read_reg2, read_data2, exp_read(read_reg2));
      end
      tick();
      n_tests++;
      if (a_out !== model_a || b_out !== model_b) begin
        n_fail++; $display("FAIL rand_ab cyc %0d got %h/%h want %h/%h", c, a_out, b_out, model_a, model_b);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_a = '0;
    model_b = '0;
    idle();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass_latch();
    test_reset_priority();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
